// File: rtl/object_move_pkg.sv
// object_move_pkg
//   Shared types and constants for the object motion controller.
//   - state_e     : stun/respawn FSM states
//   - EDGE_*      : bit positions inside HitEdgeCode / block flags
//   - fp_width()  : width of the signed fixed-point position register
package object_move_pkg;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_STUNNED = 1'b1
  } state_e;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  // One guard bit above pixel range plus the fraction, so the sum of a
  // position and a velocity can never wrap before it is clamped.
  function automatic int fp_width(input int pixel_width, input int frac_bits);
    return pixel_width + frac_bits + 1;
  endfunction

endpackage

// File: rtl/axis_step.sv
// axis_step
//   One motion axis: picks the velocity from the two opposing buttons,
//   optionally ramps toward it, zeroes it toward a blocked edge, adds it to
//   the fixed-point position and clamps the result to [MIN_PX..MAX_PX].
//   Config macro: MOVER_ACCEL_EN (velocity ramps by ACCEL per frame).
// Ports
//   clk, resetN        clock, synchronous active-low reset
//   clear              return to INIT_PX with zero velocity (respawn)
//   hold               force velocity to 0, position frozen (stun)
//   step               apply one frame of motion
//   dir_neg, dir_pos   button toward decreasing / increasing coordinate
//   block_neg/pos      edge on the decreasing / increasing side is blocked
//   pos                signed fixed-point position
//   vel_nz_next        velocity a step would commit is nonzero
module axis_step #(
  parameter int POS_W     = 18,
  parameter int FRAC_BITS = 6,
  parameter int INIT_PX   = 300,
  parameter int MIN_PX    = 0,
  parameter int MAX_PX    = 608,
  parameter int SPEED     = 128,
  parameter int ACCEL     = 32
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    clear,
  input  logic                    hold,
  input  logic                    step,
  input  logic                    dir_neg,
  input  logic                    dir_pos,
  input  logic                    block_neg,
  input  logic                    block_pos,
  output logic signed [POS_W-1:0] pos,
  output logic                    vel_nz_next
);

`ifdef MOVER_ACCEL_EN
  localparam bit ACCEL_EN = 1'b1;
`else
  localparam bit ACCEL_EN = 1'b0;
`endif

  localparam logic signed [POS_W-1:0] INIT_FP = POS_W'(INIT_PX * (2 ** FRAC_BITS));
  localparam logic signed [POS_W:0]   MIN_FP  = (POS_W+1)'(MIN_PX * (2 ** FRAC_BITS));
  localparam logic signed [POS_W:0]   MAX_FP  = (POS_W+1)'(MAX_PX * (2 ** FRAC_BITS));
  localparam logic signed [POS_W-1:0] SPEED_V = POS_W'(SPEED);
  localparam logic signed [POS_W-1:0] ACCEL_V = POS_W'(ACCEL);

  logic signed [POS_W-1:0] vel;
  logic signed [POS_W-1:0] target;
  logic signed [POS_W-1:0] ramp;
  logic signed [POS_W-1:0] vel_new;
  logic signed [POS_W:0]   sum;
  logic signed [POS_W-1:0] pos_new;
  logic                    ramp_neg;
  logic                    ramp_pos;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    target = '0;
    if (dir_pos && !dir_neg)      target = SPEED_V;
    else if (dir_neg && !dir_pos) target = -SPEED_V;

    // Step toward the target by ACCEL, landing exactly on it when closer.
    ramp = target;
    if (ACCEL_EN) begin
      if (vel < target)      ramp = (target - vel > ACCEL_V) ? vel + ACCEL_V : target;
      else if (vel > target) ramp = (vel - target > ACCEL_V) ? vel - ACCEL_V : target;
    end

    ramp_neg = ramp[POS_W-1];
    ramp_pos = (ramp != '0) && !ramp[POS_W-1];
    vel_new  = ramp;
    if ((ramp_neg && block_neg) || (ramp_pos && block_pos)) vel_new = '0;

    sum     = (POS_W+1)'(pos) + (POS_W+1)'(vel_new);
    pos_new = POS_W'(sum);
    if (sum < MIN_FP)      pos_new = POS_W'(MIN_FP);
    else if (sum > MAX_FP) pos_new = POS_W'(MAX_FP);
  end

  assign vel_nz_next = (vel_new != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetN || clear) begin
      pos <= INIT_FP;
      vel <= '0;
    end else if (hold) begin
      vel <= '0;
    end else if (step) begin
      vel <= vel_new;
      pos <= pos_new;
    end
  end

endmodule

// File: rtl/object_move_ctrl.sv
// object_move_ctrl
//   Per-object motion controller: fixed-point X/Y position driven by
//   direction buttons, clamped to a bounding box, with per-frame edge
//   blocking from collisions and a stun/respawn state machine.
//   Config macro: MOVER_ACCEL_EN (velocity ramps by ACCEL per frame instead
//   of jumping straight to the target speed).
// Ports
//   clk, resetN                 clock, synchronous active-low reset
//   startOfFrame                1-cycle pulse per video frame
//   move_left/right/up/down     held direction requests
//   collision, HitEdgeCode      edge contact this cycle, [3]=L [2]=T [1]=R [0]=B
//   hit                         pulse: object was shot (stuns it)
//   respawn                     pulse: back to initial position, active
//   topLeftX, topLeftY          signed pixel coordinates (two's complement)
//   moving                      either velocity component nonzero
//   stunned                     object frozen after a hit
module object_move_ctrl #(
  parameter int PIXEL_WIDTH = 11,
  parameter int FRAC_BITS   = 6,
  parameter int INITIAL_X   = 300,
  parameter int INITIAL_Y   = 400,
  parameter int MIN_X       = 0,
  parameter int MAX_X       = 608,
  parameter int MIN_Y       = 280,
  parameter int MAX_Y       = 450,
  parameter int X_SPEED     = 128,
  parameter int Y_SPEED     = 128,
  parameter int ACCEL       = 32,
  parameter int STUN_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   move_up,
  input  logic                   move_down,
  input  logic                   collision,
  input  logic [3:0]             HitEdgeCode,
  input  logic                   hit,
  input  logic                   respawn,
  output logic [PIXEL_WIDTH-1:0] topLeftX,
  output logic [PIXEL_WIDTH-1:0] topLeftY,
  output logic                   moving,
  output logic                   stunned
);

  import object_move_pkg::*;

  localparam int POS_W = fp_width(PIXEL_WIDTH, FRAC_BITS);
  localparam int CNT_W = $clog2(STUN_FRAMES + 1);

  state_e                  state;
  state_e                  state_d;
  logic [CNT_W-1:0]        stun_cnt;
  logic [CNT_W-1:0]        stun_cnt_d;
  logic [3:0]              block_flags;
  logic [3:0]              edge_set;
  logic [3:0]              block_now;
  logic                    take_hit;
  logic                    hold_vel;
  logic                    frame_step;
  logic signed [POS_W-1:0] x_pos;
  logic signed [POS_W-1:0] y_pos;
  logic                    x_nz;
  logic                    y_nz;

  assign edge_set   = collision ? HitEdgeCode : 4'b0000;
  // A contact reported in the frame-update cycle itself still blocks.
  assign block_now  = block_flags | edge_set;
  assign take_hit   = (state == ST_ACTIVE) && hit;
  assign hold_vel   = take_hit || (state == ST_STUNNED);
  // A hit landing on the frame pulse stuns instead of moving.
  assign frame_step = startOfFrame && (state == ST_ACTIVE) && !hit;

  axis_step #(
    .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .INIT_PX(INITIAL_X),
    .MIN_PX(MIN_X), .MAX_PX(MAX_X), .SPEED(X_SPEED), .ACCEL(ACCEL)
  ) u_axis_x (
    .clk(clk), .resetN(resetN), .clear(respawn), .hold(hold_vel), .step(frame_step),
    .dir_neg(move_left), .dir_pos(move_right),
    .block_neg(block_now[EDGE_LEFT]), .block_pos(block_now[EDGE_RIGHT]),
    .pos(x_pos), .vel_nz_next(x_nz)
  );

  axis_step #(
    .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .INIT_PX(INITIAL_Y),
    .MIN_PX(MIN_Y), .MAX_PX(MAX_Y), .SPEED(Y_SPEED), .ACCEL(ACCEL)
  ) u_axis_y (
    .clk(clk), .resetN(resetN), .clear(respawn), .hold(hold_vel), .step(frame_step),
    .dir_neg(move_up), .dir_pos(move_down),
    .block_neg(block_now[EDGE_TOP]), .block_pos(block_now[EDGE_BOTTOM]),
    .pos(y_pos), .vel_nz_next(y_nz)
  );

  // Floor to whole pixels; the arithmetic shift keeps negatives rounding down.
  assign topLeftX = PIXEL_WIDTH'(x_pos >>> FRAC_BITS);
  assign topLeftY = PIXEL_WIDTH'(y_pos >>> FRAC_BITS);

  always_comb begin
    state_d    = state;
    stun_cnt_d = stun_cnt;
    if (respawn) begin
      state_d    = ST_ACTIVE;
      stun_cnt_d = '0;
    end else begin
      case (state)
        ST_ACTIVE: begin
          if (hit) begin
            state_d    = ST_STUNNED;
            stun_cnt_d = CNT_W'(STUN_FRAMES);
          end
        end
        ST_STUNNED: begin
          // Further hits are ignored; only frames count the stun down.
          if (startOfFrame) begin
            stun_cnt_d = stun_cnt - 1'b1;
            if (stun_cnt_d == '0) state_d = ST_ACTIVE;
          end
        end
        default: state_d = ST_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state    <= ST_ACTIVE;
      stun_cnt <= '0;
      stunned  <= 1'b0;
    end else begin
      state    <= state_d;
      stun_cnt <= stun_cnt_d;
      stunned  <= (state_d == ST_STUNNED);
    end
  end

  // Flags accumulate during a frame and are consumed by the frame update;
  // a contact in that same cycle re-arms them for the next frame.
  always_ff @(posedge clk) begin
    if (!resetN || respawn)  block_flags <= 4'b0000;
    else if (startOfFrame)   block_flags <= edge_set;
    else                     block_flags <= block_flags | edge_set;
  end

  always_ff @(posedge clk) begin
    if (!resetN || respawn) moving <= 1'b0;
    else if (hold_vel)      moving <= 1'b0;
    else if (frame_step)    moving <= x_nz || y_nz;
  end

endmodule
